// File: rtl/l2_tag_mesi_engine_if.sv
// Request/response handshake bundle for the L2 tag/MESI engine.
// master drives requests and accepts responses; slave is the engine.
interface l2_tag_mesi_engine_if #(
  parameter int PA_BITS = 32,
  parameter int WAY_W   = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [PA_BITS-1:0] req_addr;
  logic [1:0]         req_snoop_in;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic [2:0]         resp_bus_op;
  logic [1:0]         resp_snoop_out;
  logic [WAY_W-1:0]   resp_way;
  logic [1:0]         resp_mesi;
  logic               resp_evict_valid;
  logic [PA_BITS-1:0] resp_evict_addr;

  modport master (
    output req_valid, req_op, req_addr, req_snoop_in, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_bus_op,
    input  resp_snoop_out, resp_way, resp_mesi,
    input  resp_evict_valid, resp_evict_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_snoop_in, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_bus_op,
    output resp_snoop_out, resp_way, resp_mesi,
    output resp_evict_valid, resp_evict_addr
  );
endinterface

// File: rtl/l2_tag_mesi_engine.sv
// L2 tag/MESI/LRU stage: lookup, state+LRU update, snoop reply, victim.
// Ports: clk, rst_n (async low), bus (slave modport); L2_TAG_STATS_EN adds stat_hits/stat_misses.
module l2_tag_mesi_engine #(
  parameter int PA_BITS    = 32,
  parameter int L2_SIZE_KB = 256,
  parameter int L2_ASSOC   = 8,
  parameter int L2_LINE_SZ = 64
) (
  input logic clk,
  input logic rst_n,
  l2_tag_mesi_engine_if.slave bus
`ifdef L2_TAG_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int OFF_W   = $clog2(L2_LINE_SZ);
  localparam int WAY_W   = $clog2(L2_ASSOC);
  localparam int INDEX_W = $clog2(L2_SIZE_KB*1024) - WAY_W - OFF_W;
  localparam int TAG_W   = PA_BITS - INDEX_W - OFF_W;
  localparam int SETS    = 1 << INDEX_W;

  localparam logic [2:0] OP_RD   = 3'd0;
  localparam logic [2:0] OP_WR   = 3'd1;
  localparam logic [2:0] OP_SRD  = 3'd2;
  localparam logic [2:0] OP_SWR  = 3'd3;
  localparam logic [2:0] OP_RWIM = 3'd4;
  localparam logic [2:0] OP_SINV = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  localparam logic [1:0] INV  = 2'd0;
  localparam logic [1:0] MOD  = 2'd1;
  localparam logic [1:0] EXCL = 2'd2;
  localparam logic [1:0] SHRD = 2'd3;

  localparam logic [1:0] NOTHIT = 2'd0;
  localparam logic [1:0] HIT    = 2'd1;
  localparam logic [1:0] HITM   = 2'd2;

  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_READ = 3'd1;
  localparam logic [2:0] B_INV  = 3'd3;
  localparam logic [2:0] B_RWIM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_UPDATE, S_RESP, S_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic [PA_BITS-1:0] addr_q;
  logic [1:0]         snp_q;
  logic [INDEX_W-1:0] clr_idx_q;

  logic [TAG_W-1:0] tag_q  [SETS][L2_ASSOC];
  logic [1:0]       mesi_q [SETS][L2_ASSOC];
  logic [WAY_W-1:0] ru_q   [SETS][L2_ASSOC];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  assign idx = addr_q[OFF_W +: INDEX_W];
  assign tag = addr_q[PA_BITS-1 -: TAG_W];

  logic unused_off;
  assign unused_off = ^addr_q[OFF_W-1:0];

  logic accept;
  assign accept = bus.req_valid && (state_q == S_IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.req_valid)
          state_d = (bus.req_op == OP_CLR) ? S_CLEAR : S_LOOKUP;
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      S_CLEAR:
        if (clr_idx_q == INDEX_W'(SETS-1)) state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      snp_q     <= '0;
      clr_idx_q <= '0;
    end else begin
      if (accept) begin
        op_q      <= bus.req_op;
        addr_q    <= bus.req_addr;
        snp_q     <= bus.req_snoop_in;
        clr_idx_q <= '0;
      end else if (state_q == S_CLEAR) begin
        clr_idx_q <= clr_idx_q + 1'b1;
      end
    end
  end

  // set lookup: match way, lowest INV way, and LRU way
  logic             hit_c, inv_c;
  logic [WAY_W-1:0] hway_c, iway_c, lway_c;
  always_comb begin
    hit_c  = 1'b0;
    inv_c  = 1'b0;
    hway_c = '0;
    iway_c = '0;
    lway_c = '0;
    for (int w = L2_ASSOC-1; w >= 0; w--) begin
      if (mesi_q[idx][WAY_W'(w)] != INV &&
          tag_q[idx][WAY_W'(w)] == tag) begin
        hit_c  = 1'b1;
        hway_c = WAY_W'(w);
      end
      if (mesi_q[idx][WAY_W'(w)] == INV) begin
        inv_c  = 1'b1;
        iway_c = WAY_W'(w);
      end
      if (ru_q[idx][WAY_W'(w)] == WAY_W'(L2_ASSOC-1))
        lway_c = WAY_W'(w);
    end
  end

  logic             hit_l;
  logic [WAY_W-1:0] hway_l, vway_l;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_l  <= 1'b0;
      hway_l <= '0;
      vway_l <= '0;
    end else if (state_q == S_LOOKUP) begin
      hit_l  <= hit_c;
      hway_l <= hway_c;
      vway_l <= inv_c ? iway_c : lway_c;
    end
  end

  // update decisions
  logic [1:0]         old_mesi, vic_mesi;
  logic               u_hit, u_ev, mesi_en, lru_en, tag_en;
  logic [2:0]         u_bus;
  logic [1:0]         u_snp, u_mesi;
  logic [WAY_W-1:0]   u_way;
  logic [PA_BITS-1:0] u_eaddr;

  assign old_mesi = mesi_q[idx][hway_l];
  assign vic_mesi = mesi_q[idx][vway_l];

  always_comb begin
    u_hit   = 1'b0;
    u_ev    = 1'b0;
    u_bus   = B_NONE;
    u_snp   = NOTHIT;
    u_mesi  = INV;
    u_way   = '0;
    u_eaddr = '0;
    mesi_en = 1'b0;
    lru_en  = 1'b0;
    tag_en  = 1'b0;
    unique case (op_q)
      OP_RD, OP_WR: begin
        u_hit   = hit_l;
        u_way   = hit_l ? hway_l : vway_l;
        mesi_en = 1'b1;
        lru_en  = 1'b1;
        if (hit_l) begin
          if (op_q == OP_RD) begin
            u_mesi = old_mesi;
          end else begin
            u_mesi = MOD;
            if (old_mesi == SHRD) u_bus = B_INV;
          end
        end else begin
          tag_en = 1'b1;
          if (op_q == OP_RD) begin
            u_bus  = B_READ;
            u_mesi = (snp_q != NOTHIT) ? SHRD : EXCL;
          end else begin
            u_bus  = B_RWIM;
            u_mesi = MOD;
          end
          if (vic_mesi == MOD) begin
            u_ev    = 1'b1;
            u_eaddr = {tag_q[idx][vway_l], idx, {OFF_W{1'b0}}};
          end
        end
      end
      OP_SRD, OP_SWR, OP_RWIM, OP_SINV: begin
        u_hit = hit_l;
        if (hit_l) begin
          u_way   = hway_l;
          u_mesi  = old_mesi;
          mesi_en = 1'b1;
          unique case (op_q)
            OP_SRD: begin
              u_mesi = SHRD;
              u_snp  = (old_mesi == MOD) ? HITM : HIT;
            end
            OP_RWIM: begin
              u_mesi = INV;
              u_snp  = (old_mesi == MOD) ? HITM : HIT;
            end
            OP_SINV:
              if (old_mesi == SHRD) begin
                u_mesi = INV;
                u_snp  = HIT;
              end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // tag array carries no reset: a line is only trusted when mesi != INV
  always_ff @(posedge clk) begin
    if (state_q == S_UPDATE && tag_en)
      tag_q[idx][u_way] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < L2_ASSOC; w++) begin
          mesi_q[INDEX_W'(s)][WAY_W'(w)] <= INV;
          ru_q[INDEX_W'(s)][WAY_W'(w)]   <= WAY_W'(w);
        end
    end else if (state_q == S_CLEAR) begin
      for (int w = 0; w < L2_ASSOC; w++) begin
        mesi_q[clr_idx_q][WAY_W'(w)] <= INV;
        ru_q[clr_idx_q][WAY_W'(w)]   <= WAY_W'(w);
      end
    end else if (state_q == S_UPDATE) begin
      if (mesi_en) mesi_q[idx][u_way] <= u_mesi;
      if (lru_en)
        for (int w = 0; w < L2_ASSOC; w++) begin
          if (WAY_W'(w) == u_way)
            ru_q[idx][WAY_W'(w)] <= '0;
          else if (ru_q[idx][WAY_W'(w)] < ru_q[idx][u_way])
            ru_q[idx][WAY_W'(w)] <= ru_q[idx][WAY_W'(w)] + 1'b1;
        end
    end
  end

  // response registers
  logic               r_hit, r_ev;
  logic [2:0]         r_bus;
  logic [1:0]         r_snp, r_mesi;
  logic [WAY_W-1:0]   r_way;
  logic [PA_BITS-1:0] r_eaddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit   <= 1'b0;
      r_ev    <= 1'b0;
      r_bus   <= '0;
      r_snp   <= '0;
      r_mesi  <= '0;
      r_way   <= '0;
      r_eaddr <= '0;
    end else if (state_q == S_UPDATE) begin
      r_hit   <= u_hit;
      r_ev    <= u_ev;
      r_bus   <= u_bus;
      r_snp   <= u_snp;
      r_mesi  <= u_mesi;
      r_way   <= u_way;
      r_eaddr <= u_eaddr;
    end else if (state_q == S_CLEAR) begin
      r_hit   <= 1'b0;
      r_ev    <= 1'b0;
      r_bus   <= '0;
      r_snp   <= '0;
      r_mesi  <= '0;
      r_way   <= '0;
      r_eaddr <= '0;
    end
  end

  assign bus.resp_hit         = r_hit;
  assign bus.resp_bus_op      = r_bus;
  assign bus.resp_snoop_out   = r_snp;
  assign bus.resp_way         = r_way;
  assign bus.resp_mesi        = r_mesi;
  assign bus.resp_evict_valid = r_ev;
  assign bus.resp_evict_addr  = r_eaddr;

`ifdef L2_TAG_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == S_CLEAR) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == S_UPDATE &&
                 (op_q == OP_RD || op_q == OP_WR)) begin
      if (hit_l) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_l2_tag_mesi_engine.sv
// Directed table-driven bench for l2_tag_mesi_engine.
// Covers MESI/LRU/victim behaviour, resp hold, clear and async reset.
module tb_l2_tag_mesi_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_tag_mesi_engine_if #(.PA_BITS(32), .WAY_W(3)) b ();

`ifdef L2_TAG_STATS_EN
  logic [31:0] sh, sm;
`endif

  l2_tag_mesi_engine #(
    .PA_BITS(32), .L2_SIZE_KB(256), .L2_ASSOC(8), .L2_LINE_SZ(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
`ifdef L2_TAG_STATS_EN
    ,
    .stat_hits(sh),
    .stat_misses(sm)
`endif
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  snp;
    logic        hit;
    logic [2:0]  bus;
    logic [1:0]  so;
    logic [2:0]  way;
    logic [1:0]  mesi;
    logic        ev;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];
  int ntests = 0;
  int nfail  = 0;

  task automatic add(string n, logic [2:0] op, logic [31:0] a,
                     logic [1:0] s, logic h, logic [2:0] bo,
                     logic [1:0] so, logic [2:0] w, logic [1:0] m,
                     logic ev, logic [31:0] ea);
    vec_t v;
    v.name = n; v.op = op; v.addr = a; v.snp = s; v.hit = h;
    v.bus = bo; v.so = so; v.way = w; v.mesi = m; v.ev = ev; v.ea = ea;
    tbl.push_back(v);
  endtask

  function automatic logic [43:0] pk(logic h, logic [2:0] bo,
      logic [1:0] so, logic [2:0] w, logic [1:0] m, logic ev,
      logic [31:0] ea);
    return {h, bo, so, w, m, ev, ea};
  endfunction

  function automatic logic [43:0] dut_resp();
    return pk(b.resp_hit, b.resp_bus_op, b.resp_snoop_out, b.resp_way,
              b.resp_mesi, b.resp_evict_valid, b.resp_evict_addr);
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [1:0] s, output int lat);
    @(negedge clk);
    b.req_valid = 1'b1;
    b.req_op = op;
    b.req_addr = a;
    b.req_snoop_in = s;
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    lat = 1;
    while (!b.resp_valid && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    b.resp_ready = 1'b1;
    @(posedge clk);
    #1 b.resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int eh, em;
    logic [43:0] exp;
    eh = 0;
    em = 0;
    b.req_valid = 1'b0;
    b.req_op = '0;
    b.req_addr = '0;
    b.req_snoop_in = '0;
    b.resp_ready = 1'b0;

    // vectors: name op addr snp | hit bus so way mesi ev eaddr
    add("rd_miss",    0, 32'h0000_1040, 0, 0, 1, 0, 0, 2, 0, 0);
    add("rd_hit",     0, 32'h0000_1040, 0, 1, 0, 0, 0, 2, 0, 0);
    add("wr_hit_ex",  1, 32'h0000_1040, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int t = 1; t < 8; t++)
      add("fill", 0, (32'(t) << 15) | 32'h1040, 0,
          0, 1, 0, 3'(t), 2, 0, 0);
    add("evict_t0",   0, 32'h0004_1040, 1, 0, 1, 0, 0, 3, 1, 32'h1040);
    add("wr_hit_sh",  1, 32'h0004_1040, 0, 1, 3, 0, 0, 1, 0, 0);
    add("srd_mod",    2, 32'h0004_1040, 0, 1, 0, 2, 0, 3, 0, 0);
    add("rwim_shrd",  4, 32'h0004_1040, 0, 1, 0, 1, 0, 0, 0, 0);
    add("srd_miss",   2, 32'h0004_1040, 0, 0, 0, 0, 0, 0, 0, 0);
    add("srd_excl",   2, 32'h0000_9040, 0, 1, 0, 1, 1, 3, 0, 0);
    add("sinv_excl",  5, 32'h0001_1040, 0, 1, 0, 0, 2, 2, 0, 0);
    add("sinv_shrd",  5, 32'h0000_9040, 0, 1, 0, 1, 1, 0, 0, 0);
    add("swr_excl",   3, 32'h0001_9040, 0, 1, 0, 0, 3, 2, 0, 0);
    add("rwim_excl",  4, 32'h0002_1040, 0, 1, 0, 1, 4, 0, 0, 0);
    add("op7",        7, 32'h0001_9040, 0, 0, 0, 0, 0, 0, 0, 0);
    add("wr_miss",    1, 32'h0004_9040, 0, 0, 4, 0, 0, 1, 0, 0);
    add("rd_hitm_in", 0, 32'h0005_1040, 2, 0, 1, 0, 1, 3, 0, 0);
    add("rd_hit_t3",  0, 32'h0001_9040, 0, 1, 0, 0, 3, 2, 0, 0);
    add("wr_miss_w4", 1, 32'h0005_9040, 0, 0, 4, 0, 4, 1, 0, 0);
    add("lru_w2",     0, 32'h0006_1040, 0, 0, 1, 0, 2, 2, 0, 0);
    add("lru_w5",     0, 32'h0006_9040, 0, 0, 1, 0, 5, 2, 0, 0);
    add("wr_hit_w6",  1, 32'h0003_1040, 0, 1, 0, 0, 6, 1, 0, 0);
    add("lru_w7",     0, 32'h0007_1040, 0, 0, 1, 0, 7, 2, 0, 0);
    add("evict_t9",   0, 32'h0007_9040, 0, 0, 1, 0, 0, 2, 1, 32'h0004_9040);
    add("other_set",  0, 32'h0000_1000, 0, 0, 1, 0, 0, 2, 0, 0);

    repeat (3) @(posedge clk);
    chk("reset_hold", {b.req_ready, b.resp_valid}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_state", {b.req_ready, b.resp_valid, dut_resp()},
        {2'b10, 44'h0});

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].addr, tbl[i].snp, lat);
      chk({tbl[i].name, "_lat"}, 64'(lat), 64'd3);
      exp = pk(tbl[i].hit, tbl[i].bus, tbl[i].so, tbl[i].way,
               tbl[i].mesi, tbl[i].ev, tbl[i].ea);
      chk(tbl[i].name, dut_resp(), exp);
      if (tbl[i].op < 3'd2) begin
        if (tbl[i].hit) eh++;
        else em++;
      end
      finish_resp();
    end

`ifdef L2_TAG_STATS_EN
    chk("stat_hits", sh, eh);
    chk("stat_misses", sm, em);
`endif

    // SHRD write with consumer stalled for 5 cycles
    send(3'd1, 32'h0005_1040, 2'd0, lat);
    exp = pk(1, 3, 0, 1, 1, 0, 0);
    chk("hold_first", {b.resp_valid, b.req_ready, dut_resp()},
        {2'b10, exp});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 chk("hold_stable", {b.resp_valid, b.req_ready, dut_resp()},
             {2'b10, exp});
    end
    finish_resp();
    chk("hold_release", {b.resp_valid, b.req_ready}, 2'b01);

    // clear walks every set then answers with zeros
    send(3'd6, 32'h0, 2'd0, lat);
    chk("clear_lat", 64'(lat), 64'd513);
    chk("clear_resp", dut_resp(), 44'h0);
`ifdef L2_TAG_STATS_EN
    chk("stat_clr", {sh, sm}, 64'h0);
`endif
    finish_resp();
    send(3'd0, 32'h0005_1040, 2'd0, lat);
    chk("post_clear", dut_resp(), pk(0, 1, 0, 0, 2, 0, 0));
    finish_resp();

    // async reset while in LOOKUP
    @(negedge clk);
    b.req_valid = 1'b1;
    b.req_op = 3'd0;
    b.req_addr = 32'h0000_1000;
    b.req_snoop_in = 2'd0;
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    chk("lookup_busy", {b.req_ready, b.resp_valid}, 2'b00);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {b.req_ready, b.resp_valid, dut_resp()},
           {2'b10, 44'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd0, 32'h0000_1000, 2'd0, lat);
    chk("after_rst_lat", 64'(lat), 64'd3);
    chk("after_rst", dut_resp(), pk(0, 1, 0, 0, 2, 0, 0));
    finish_resp();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
